// File: rtl/axi_mem_responder.sv
// AXI4 slave memory model: serves 32-bit INCR bursts (up to 16 beats) from a word array.
// The read and write channels are independent, with one outstanding burst per direction.
module axi_mem_responder #(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned ID_W      = 4
) (
  input  logic            clk_i,
  input  logic            arst_ni,
  input  logic            aw_valid_i,
  output logic            aw_ready_o,
  input  logic [63:0]     aw_addr_i,
  input  logic [7:0]      aw_len_i,
  input  logic [2:0]      aw_size_i,
  input  logic [1:0]      aw_burst_i,
  input  logic [ID_W-1:0] aw_id_i,
  input  logic            w_valid_i,
  output logic            w_ready_o,
  input  logic [31:0]     w_data_i,
  input  logic [3:0]      w_strb_i,
  input  logic            w_last_i,
  output logic            b_valid_o,
  input  logic            b_ready_i,
  output logic [1:0]      b_resp_o,
  output logic [ID_W-1:0] b_id_o,
  input  logic            ar_valid_i,
  output logic            ar_ready_o,
  input  logic [63:0]     ar_addr_i,
  input  logic [7:0]      ar_len_i,
  input  logic [2:0]      ar_size_i,
  input  logic [1:0]      ar_burst_i,
  input  logic [ID_W-1:0] ar_id_i,
  output logic            r_valid_o,
  input  logic            r_ready_i,
  output logic [31:0]     r_data_o,
  output logic [1:0]      r_resp_o,
  output logic            r_last_o,
  output logic [ID_W-1:0] r_id_o
);
  localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;

  w_state_e r_w_state, w_w_state_nxt;
  r_state_e r_r_state, w_r_state_nxt;

  logic [31:0] r_mem [MEM_WORDS];

  logic [63:0]     r_w_addr, r_r_addr;
  logic [7:0]      r_w_len, r_w_cnt, r_r_len, r_r_cnt;
  logic [ID_W-1:0] r_w_id, r_r_id;
  logic            r_w_bad, r_w_err, r_r_bad;

  logic            w_aw_hs, w_w_hs, w_ar_hs, w_r_hs, w_w_final, w_w_we;
  logic            w_aw_bad, w_ar_bad, w_w_inr, w_r_inr;
  logic [63:0]     w_w_woff, w_r_woff;
  logic [IDX_W-1:0] w_w_idx, w_r_idx;

  // Unsupported burst shapes fail the whole burst.
  assign w_aw_bad = (aw_burst_i != 2'b01) || (aw_size_i != 3'b010) || (aw_len_i > 8'd15);
  assign w_ar_bad = (ar_burst_i != 2'b01) || (ar_size_i != 3'b010) || (ar_len_i > 8'd15);

  assign w_w_woff = (r_w_addr - BASE_ADDR) >> 2;
  assign w_r_woff = (r_r_addr - BASE_ADDR) >> 2;
  assign w_w_inr  = (r_w_addr >= BASE_ADDR) && (w_w_woff < 64'(MEM_WORDS));
  assign w_r_inr  = (r_r_addr >= BASE_ADDR) && (w_r_woff < 64'(MEM_WORDS));
  assign w_w_idx  = w_w_woff[IDX_W-1:0];
  assign w_r_idx  = w_r_woff[IDX_W-1:0];

  assign w_aw_hs   = aw_valid_i && (r_w_state == W_IDLE);
  assign w_w_hs    = w_valid_i && (r_w_state == W_DATA);
  assign w_ar_hs   = ar_valid_i && (r_r_state == R_IDLE);
  assign w_r_hs    = r_ready_i && (r_r_state == R_DATA);
  assign w_w_final = (r_w_cnt == r_w_len);
  assign w_w_we    = w_w_hs && !r_w_bad && w_w_inr;

  // Write FSM: state register, next state, outputs.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) r_w_state <= W_IDLE;
    else          r_w_state <= w_w_state_nxt;
  end

  always_comb begin
    w_w_state_nxt = r_w_state;
    case (r_w_state)
      W_IDLE:  if (aw_valid_i) w_w_state_nxt = W_DATA;
      W_DATA:  if (w_valid_i && w_w_final) w_w_state_nxt = W_RESP;
      W_RESP:  if (b_ready_i) w_w_state_nxt = W_IDLE;
      default: w_w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;
    b_resp_o   = RESP_OKAY;
    case (r_w_state)
      W_IDLE:  aw_ready_o = 1'b1;
      W_DATA:  w_ready_o  = 1'b1;
      W_RESP: begin
        b_valid_o = 1'b1;
        b_resp_o  = r_w_err ? RESP_SLVERR : RESP_OKAY;
      end
      default: ;
    endcase
  end

  assign b_id_o = r_w_id;

  // Write burst context; the error flag starts with the burst-level verdict.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_w_addr <= '0;
      r_w_len  <= '0;
      r_w_cnt  <= '0;
      r_w_id   <= '0;
      r_w_bad  <= 1'b0;
      r_w_err  <= 1'b0;
    end else if (w_aw_hs) begin
      r_w_addr <= aw_addr_i & ~64'h3;
      r_w_len  <= aw_len_i;
      r_w_cnt  <= '0;
      r_w_id   <= aw_id_i;
      r_w_bad  <= w_aw_bad;
      r_w_err  <= w_aw_bad;
    end else if (w_w_hs) begin
      r_w_addr <= r_w_addr + 64'd4;
      r_w_cnt  <= r_w_cnt + 8'd1;
      r_w_err  <= r_w_err | !w_w_inr | (w_last_i != w_w_final);
    end
  end

  // Array is not reset; byte lanes follow the strobes.
  always_ff @(posedge clk_i) begin
    if (w_w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb_i[b]) r_mem[w_w_idx][8*b +: 8] <= w_data_i[8*b +: 8];
      end
    end
  end

  // Read FSM: state register, next state, outputs.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) r_r_state <= R_IDLE;
    else          r_r_state <= w_r_state_nxt;
  end

  always_comb begin
    w_r_state_nxt = r_r_state;
    case (r_r_state)
      R_IDLE:  if (ar_valid_i) w_r_state_nxt = R_DATA;
      R_DATA:  if (r_ready_i && (r_r_cnt == r_r_len)) w_r_state_nxt = R_IDLE;
      default: w_r_state_nxt = R_IDLE;
    endcase
  end

  // Read data comes straight from the array, so a same-cycle write is seen next cycle.
  always_comb begin
    ar_ready_o = 1'b0;
    r_valid_o  = 1'b0;
    r_data_o   = '0;
    r_resp_o   = RESP_OKAY;
    r_last_o   = 1'b0;
    case (r_r_state)
      R_IDLE: ar_ready_o = 1'b1;
      R_DATA: begin
        r_valid_o = 1'b1;
        r_last_o  = (r_r_cnt == r_r_len);
        if (!r_r_bad && w_r_inr) r_data_o = r_mem[w_r_idx];
        else                     r_resp_o = RESP_SLVERR;
      end
      default: ;
    endcase
  end

  assign r_id_o = r_r_id;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_r_addr <= '0;
      r_r_len  <= '0;
      r_r_cnt  <= '0;
      r_r_id   <= '0;
      r_r_bad  <= 1'b0;
    end else if (w_ar_hs) begin
      r_r_addr <= ar_addr_i & ~64'h3;
      r_r_len  <= ar_len_i;
      r_r_cnt  <= '0;
      r_r_id   <= ar_id_i;
      r_r_bad  <= w_ar_bad;
    end else if (w_r_hs) begin
      r_r_addr <= r_r_addr + 64'd4;
      r_r_cnt  <= r_r_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomized bench for axi_mem_responder, checked against a word-array model of the memory.
module tb_axi_mem_responder;
  localparam logic [63:0] BASE = 64'h1000;
  localparam int unsigned MW   = 256;
  localparam int unsigned IDW  = 4;

  logic           clk_i = 1'b0;
  logic           arst_ni;
  logic           aw_valid_i, aw_ready_o, w_valid_i, w_ready_o, w_last_i;
  logic [63:0]    aw_addr_i, ar_addr_i;
  logic [7:0]     aw_len_i, ar_len_i;
  logic [2:0]     aw_size_i, ar_size_i;
  logic [1:0]     aw_burst_i, ar_burst_i, b_resp_o, r_resp_o;
  logic [IDW-1:0] aw_id_i, ar_id_i, b_id_o, r_id_o;
  logic [31:0]    w_data_i, r_data_o;
  logic [3:0]     w_strb_i;
  logic           b_valid_o, b_ready_i, ar_valid_i, ar_ready_o;
  logic           r_valid_o, r_ready_i, r_last_o;

  axi_mem_responder #(.BASE_ADDR(BASE), .MEM_WORDS(MW), .ID_W(IDW)) dut (
    .clk_i(clk_i), .arst_ni(arst_ni),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_addr_i(aw_addr_i),
    .aw_len_i(aw_len_i), .aw_size_i(aw_size_i), .aw_burst_i(aw_burst_i), .aw_id_i(aw_id_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i),
    .w_strb_i(w_strb_i), .w_last_i(w_last_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_resp_o(b_resp_o), .b_id_o(b_id_o),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i),
    .ar_len_i(ar_len_i), .ar_size_i(ar_size_i), .ar_burst_i(ar_burst_i), .ar_id_i(ar_id_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o),
    .r_resp_o(r_resp_o), .r_last_o(r_last_o), .r_id_o(r_id_o)
  );

  always #5 clk_i = ~clk_i;

  logic [31:0] model [MW];
  bit          known [MW];
  logic [31:0] wdata [256];
  logic [3:0]  wstrb [256];
  int n_checks = 0;
  int n_fail = 0;

  function automatic bit in_range(input logic [63:0] a);
    return (a >= BASE) && (((a - BASE) / 64'd4) < 64'(MW));
  endfunction

  function automatic bit burst_ok(input logic [1:0] burst, input logic [2:0] size, input int len);
    return (burst == 2'b01) && (size == 3'b010) && (len <= 15);
  endfunction

  task automatic do_write(input logic [63:0] addr, input int len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [IDW-1:0] id,
                          input int bad_last, input int bdelay);
    int n;
    int idx;
    bit ok;
    bit err;
    logic [63:0] a;
    ok  = burst_ok(burst, size, len);
    err = !ok;
    aw_valid_i = 1'b1; aw_addr_i = addr; aw_len_i = 8'(len);
    aw_size_i = size; aw_burst_i = burst; aw_id_i = id;
    n = 0;
    while (aw_ready_o !== 1'b1 && n < 50) begin @(posedge clk_i); #1; n++; end
    n_checks++;
    if (n >= 50) begin n_fail++; $display("FAIL aw_timeout: aw_ready got %b required 1", aw_ready_o); end
    @(posedge clk_i); #1;
    aw_valid_i = 1'b0;
    for (int i = 0; i <= len; i++) begin
      w_valid_i = 1'b1; w_data_i = wdata[i]; w_strb_i = wstrb[i];
      w_last_i = (i == len) != (i == bad_last);
      if (i == bad_last) err = 1'b1;
      a = (addr & ~64'h3) + 64'(4 * i);
      if (!in_range(a)) err = 1'b1;
      else if (ok) begin
        idx = int'((a - BASE) / 64'd4);
        for (int b = 0; b < 4; b++)
          if (wstrb[i][b]) model[idx][8*b +: 8] = wdata[i][8*b +: 8];
        if (wstrb[i] == 4'hF) known[idx] = 1'b1;
      end
      n_checks++;
      if (w_ready_o !== 1'b1) begin n_fail++; $display("FAIL w_ready beat %0d: got %b required 1", i, w_ready_o); end
      @(posedge clk_i); #1;
    end
    w_valid_i = 1'b0; w_last_i = 1'b0;
    n_checks++;
    if (b_valid_o !== 1'b1 || aw_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL b_after_last: b_valid %b aw_ready %b required 1 0", b_valid_o, aw_ready_o);
    end
    for (int k = 0; k < bdelay; k++) begin
      @(posedge clk_i); #1;
      n_checks++;
      if (b_valid_o !== 1'b1 || aw_ready_o !== 1'b0) begin
        n_fail++; $display("FAIL b_hold cycle %0d: b_valid %b aw_ready %b required 1 0", k, b_valid_o, aw_ready_o);
      end
    end
    n_checks++;
    if (b_resp_o !== (err ? 2'b10 : 2'b00) || b_id_o !== id) begin
      n_fail++; $display("FAIL b_resp: resp %b id %h required %b %h", b_resp_o, b_id_o, err ? 2'b10 : 2'b00, id);
    end
    b_ready_i = 1'b1;
    @(posedge clk_i); #1;
    b_ready_i = 1'b0;
    n_checks++;
    if (b_valid_o !== 1'b0 || aw_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL b_done: b_valid %b aw_ready %b required 0 1", b_valid_o, aw_ready_o);
    end
  endtask

  // rmode: 0 always ready, 1 ready every other cycle, 2 random ready.
  task automatic do_read(input logic [63:0] addr, input int len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [IDW-1:0] id, input int rmode);
    logic [31:0] exp_d [256];
    logic [1:0]  exp_r [256];
    bit          chk_d [256];
    logic [63:0] a;
    logic [31:0] pd;
    logic [1:0]  pr;
    logic        pl;
    logic [IDW-1:0] pi;
    bit ok;
    bit have_prev;
    int n;
    int beat;
    int cyc;
    int idx;
    ok = burst_ok(burst, size, len);
    for (int i = 0; i <= len; i++) begin
      a = (addr & ~64'h3) + 64'(4 * i);
      if (ok && in_range(a)) begin
        idx = int'((a - BASE) / 64'd4);
        exp_d[i] = model[idx]; exp_r[i] = 2'b00; chk_d[i] = known[idx];
      end else begin
        exp_d[i] = 32'h0; exp_r[i] = 2'b10; chk_d[i] = 1'b1;
      end
    end
    ar_valid_i = 1'b1; ar_addr_i = addr; ar_len_i = 8'(len);
    ar_size_i = size; ar_burst_i = burst; ar_id_i = id;
    n = 0;
    while (ar_ready_o !== 1'b1 && n < 50) begin @(posedge clk_i); #1; n++; end
    n_checks++;
    if (n >= 50) begin n_fail++; $display("FAIL ar_timeout: ar_ready got %b required 1", ar_ready_o); end
    @(posedge clk_i); #1;
    ar_valid_i = 1'b0;
    beat = 0; cyc = 0; have_prev = 1'b0;
    pd = '0; pr = '0; pl = 1'b0; pi = '0;
    while (beat <= len && cyc < 400) begin
      case (rmode)
        0:       r_ready_i = 1'b1;
        1:       r_ready_i = (cyc % 2) == 1;
        default: r_ready_i = 1'($urandom_range(0, 1));
      endcase
      if (have_prev) begin
        n_checks++;
        if (r_valid_o !== 1'b1 || r_data_o !== pd || r_resp_o !== pr || r_last_o !== pl || r_id_o !== pi) begin
          n_fail++; $display("FAIL r_stable beat %0d: data %h resp %b last %b got, held %h %b %b required",
                             beat, r_data_o, r_resp_o, r_last_o, pd, pr, pl);
        end
      end
      if (rmode == 0) begin
        n_checks++;
        if (r_valid_o !== 1'b1) begin n_fail++; $display("FAIL r_bubble beat %0d: r_valid %b required 1", beat, r_valid_o); end
      end
      if (r_valid_o === 1'b1 && r_ready_i) begin
        n_checks++;
        if ((chk_d[beat] && r_data_o !== exp_d[beat]) || r_resp_o !== exp_r[beat] ||
            r_last_o !== (beat == len) || r_id_o !== id) begin
          n_fail++; $display("FAIL r_beat %0d: data %h resp %b last %b id %h, required %h %b %b %h",
                             beat, r_data_o, r_resp_o, r_last_o, r_id_o, exp_d[beat], exp_r[beat], beat == len, id);
        end
        beat++; have_prev = 1'b0;
      end else if (r_valid_o === 1'b1) begin
        have_prev = 1'b1; pd = r_data_o; pr = r_resp_o; pl = r_last_o; pi = r_id_o;
      end else have_prev = 1'b0;
      @(posedge clk_i); #1;
      cyc++;
    end
    r_ready_i = 1'b0;
    n_checks++;
    if (beat <= len) begin n_fail++; $display("FAIL r_timeout: got %0d beats required %0d", beat, len + 1); end
    n_checks++;
    if (r_valid_o !== 1'b0 || ar_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL r_done: r_valid %b ar_ready %b required 0 1", r_valid_o, ar_ready_o);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (aw_ready_o !== 1'b1 || ar_ready_o !== 1'b1 || w_ready_o !== 1'b0 || b_valid_o !== 1'b0 ||
        r_valid_o !== 1'b0 || r_last_o !== 1'b0 || b_resp_o !== 2'b00 || r_resp_o !== 2'b00 ||
        r_data_o !== 32'h0 || b_id_o !== '0 || r_id_o !== '0) begin
      n_fail++; $display("FAIL reset_state: awr %b arr %b wr %b bv %b rv %b rl %b rdata %h required 1 1 0 0 0 0 0",
                         aw_ready_o, ar_ready_o, w_ready_o, b_valid_o, r_valid_o, r_last_o, r_data_o);
    end
  endtask

  task automatic test_burst16();
    for (int i = 0; i < 16; i++) begin wdata[i] = 32'h1000 + 32'(i); wstrb[i] = 4'hF; end
    do_write(BASE + 64'h40, 15, 3'b010, 2'b01, 4'h3, -1, 0);
    do_read(BASE + 64'h40, 15, 3'b010, 2'b01, 4'h5, 0);
  endtask

  task automatic test_partial_strobe();
    wdata[0] = 32'hAABBCCDD; wstrb[0] = 4'hF;
    do_write(BASE + 64'h200, 0, 3'b010, 2'b01, 4'h1, -1, 0);
    wdata[0] = 32'h11223344; wstrb[0] = 4'b0101;
    do_write(BASE + 64'h200, 0, 3'b010, 2'b01, 4'h2, -1, 0);
    do_read(BASE + 64'h200, 0, 3'b010, 2'b01, 4'h7, 0);
  endtask

  task automatic test_out_of_range_read();
    wdata[0] = $urandom; wdata[1] = $urandom; wstrb[0] = 4'hF; wstrb[1] = 4'hF;
    do_write(BASE + 64'(4 * (MW - 2)), 1, 3'b010, 2'b01, 4'h4, -1, 0);
    do_read(BASE + 64'(4 * (MW - 2)), 3, 3'b010, 2'b01, 4'h9, 0);
    do_read(BASE - 64'h8, 3, 3'b010, 2'b01, 4'hA, 0);
  endtask

  task automatic test_illegal_burst();
    for (int i = 0; i < 4; i++) begin wdata[i] = 32'h5000 + 32'(i); wstrb[i] = 4'hF; end
    do_write(BASE + 64'h300, 3, 3'b010, 2'b01, 4'h1, -1, 0);
    for (int i = 0; i < 4; i++) wdata[i] = $urandom;
    do_write(BASE + 64'h300, 3, 3'b010, 2'b00, 4'hB, -1, 0);
    do_read(BASE + 64'h300, 3, 3'b010, 2'b01, 4'hC, 0);
    do_read(BASE + 64'h300, 3, 3'b001, 2'b01, 4'hD, 0);
  endtask

  task automatic test_wlast_mismatch();
    for (int i = 0; i < 4; i++) begin wdata[i] = $urandom; wstrb[i] = 4'hF; end
    do_write(BASE + 64'h380, 3, 3'b010, 2'b01, 4'h6, 1, 0);
    do_write(BASE + 64'h390, 3, 3'b010, 2'b01, 4'h6, 3, 0);
    do_read(BASE + 64'h380, 7, 3'b010, 2'b01, 4'h6, 0);
  endtask

  task automatic test_concurrency();
    for (int i = 0; i < 8; i++) begin wdata[i] = $urandom; wstrb[i] = 4'hF; end
    do_write(BASE + 64'(4 * 100), 7, 3'b010, 2'b01, 4'h2, -1, 0);
    for (int i = 0; i < 8; i++) wdata[i] = $urandom;
    fork
      do_read(BASE + 64'(4 * 100), 7, 3'b010, 2'b01, 4'hE, 1);
      do_write(BASE + 64'(4 * 150), 7, 3'b010, 2'b01, 4'h8, -1, 5);
    join
    do_read(BASE + 64'(4 * 150), 7, 3'b010, 2'b01, 4'hF, 2);
  endtask

  task automatic test_reset_mid_read();
    ar_valid_i = 1'b1; ar_addr_i = BASE + 64'h40; ar_len_i = 8'd7;
    ar_size_i = 3'b010; ar_burst_i = 2'b01; ar_id_i = 4'h3;
    @(posedge clk_i); #1;
    ar_valid_i = 1'b0;
    r_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (r_valid_o !== 1'b1 || r_data_o !== model[16 + i]) begin
        n_fail++; $display("FAIL pre_reset beat %0d: valid %b data %h required 1 %h", i, r_valid_o, r_data_o, model[16 + i]);
      end
      @(posedge clk_i); #1;
    end
    r_ready_i = 1'b0;
    arst_ni = 1'b0;
    #1;
    n_checks++;
    if (r_valid_o !== 1'b0 || r_last_o !== 1'b0 || r_data_o !== 32'h0 || ar_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL async_reset: r_valid %b r_last %b r_data %h ar_ready %b required 0 0 0 1",
                         r_valid_o, r_last_o, r_data_o, ar_ready_o);
    end
    @(posedge clk_i); @(posedge clk_i); #1;
    arst_ni = 1'b1;
    @(posedge clk_i); #1;
    n_checks++;
    if (ar_ready_o !== 1'b1 || r_valid_o !== 1'b0 || b_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL post_reset: ar_ready %b r_valid %b b_valid %b required 1 0 0", ar_ready_o, r_valid_o, b_valid_o);
    end
    do_read(BASE + 64'h40, 15, 3'b010, 2'b01, 4'h1, 0);
  endtask

  task automatic test_random();
    int w;
    int len;
    int sel;
    int bad_last;
    logic [63:0] addr;
    logic [1:0] burst;
    logic [2:0] size;
    for (int t = 0; t < 24; t++) begin
      w = int'($urandom_range(0, MW + 7)) - 4;
      addr = BASE + 64'(longint'(w) * 4) + 64'($urandom_range(0, 3));
      len = int'($urandom_range(0, 15));
      burst = 2'b01; size = 3'b010;
      sel = int'($urandom_range(0, 9));
      if (sel == 0) burst = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10;
      else if (sel == 1) size = 3'b001;
      else if (sel == 2) len = int'($urandom_range(16, 19));
      bad_last = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len)) : -1;
      for (int i = 0; i <= len; i++) begin wdata[i] = $urandom; wstrb[i] = 4'($urandom); end
      do_write(addr, len, size, burst, 4'($urandom), bad_last, int'($urandom_range(0, 2)));
      do_read(addr, len, size, burst, 4'($urandom), 2);
    end
  endtask

  initial begin
    arst_ni = 1'b0;
    aw_valid_i = 1'b0; aw_addr_i = '0; aw_len_i = '0; aw_size_i = '0; aw_burst_i = '0; aw_id_i = '0;
    w_valid_i = 1'b0; w_data_i = '0; w_strb_i = '0; w_last_i = 1'b0; b_ready_i = 1'b0;
    ar_valid_i = 1'b0; ar_addr_i = '0; ar_len_i = '0; ar_size_i = '0; ar_burst_i = '0; ar_id_i = '0;
    r_ready_i = 1'b0;
    for (int i = 0; i < MW; i++) begin model[i] = '0; known[i] = 1'b0; end
    #1;
    test_reset();
    repeat (3) @(posedge clk_i);
    #1;
    arst_ni = 1'b1;
    @(posedge clk_i); #1;
    test_reset();
    test_burst16();
    test_partial_strobe();
    test_out_of_range_read();
    test_illegal_burst();
    test_wlast_mismatch();
    test_concurrency();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
- AXI4 slave-side memory model: the responder for the DMA master. It serves the DMA's 32-bit INCR bursts (up to 16 beats) from an internal word-addressed SRAM array.
- Read and write channels are independent, with one outstanding burst per direction.
- Used as the DMA's memory target in the SoC fabric and as the reference target in DMA verification.

Parameters:
- BASE_ADDR, 64'h0, byte address of the first memory word.
- MEM_WORDS, 1024, depth of the array in 32-bit words.
- ID_W, 4, width of the AXI ID fields.

Ports:
- clk_i  in  1  clock
- arst_ni  in  1  reset: asynchronous, active-low
- aw_valid_i / aw_ready_o  in/out  1  write-address handshake
- aw_addr_i  in  64  burst start byte address
- aw_len_i  in  8  beats-1
- aw_size_i  in  3  beat size code
- aw_burst_i  in  2  burst type
- aw_id_i  in  ID_W  write ID
- w_valid_i / w_ready_o  in/out  1  write-data handshake
- w_data_i  in  32  write data
- w_strb_i  in  4  byte enables
- w_last_i  in  1  last-beat marker
- b_valid_o / b_ready_i  out/in  1  write-response handshake
- b_resp_o  out  2  write response
- b_id_o  out  ID_W  echo of aw_id_i
- ar_valid_i / ar_ready_o  in/out  1  read-address handshake
- ar_addr_i, ar_len_i, ar_size_i, ar_burst_i, ar_id_i  in  64/8/3/2/ID_W  same meanings as the AW fields
- r_valid_o / r_ready_i  out/in  1  read-data handshake
- r_data_o  out  32  read data
- r_resp_o  out  2  per-beat read response
- r_last_o  out  1  final beat
- r_id_o  out  ID_W  echo of ar_id_i

Behaviour:
- Reset:
  - Both FSMs go to IDLE.
  - aw_ready_o=1, ar_ready_o=1.
  - w_ready_o, b_valid_o, r_valid_o, r_last_o = 0; b_resp_o, r_resp_o, r_data_o, ids = 0.
  - Array contents are not reset.
  - Reset mid-burst aborts the burst silently; no B or R response is issued.
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: aw_ready_o=1. On an AW handshake, latch addr, len, id and the burst error flag; beat counter=0.
  - W_DATA: w_ready_o=1 starting the cycle after the AW handshake.
    - Each W handshake writes the word at the current address if that beat is legal; bytes are written per w_strb_i.
    - Address increments by 4 and the counter increments after each beat.
    - The beat where counter==len is final and moves the FSM to W_RESP.
  - W_RESP: b_valid_o=1 the cycle after the final beat, held until b_ready_i.
    - b_id_o = latched id.
    - b_resp_o=SLVERR(2'b10) if any beat errored, else OKAY.
- Read FSM, R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: ar_ready_o=1; latch on handshake.
  - R_DATA: r_valid_o=1 starting the cycle after the AR handshake.
    - r_data_o = array word at the current address, read combinationally.
    - r_last_o=1 when counter==len.
    - On each R handshake, advance address and counter. Beats are back-to-back with no bubbles while r_ready_i=1.
    - Return to R_IDLE after the handshake with r_last_o=1.
  - r_data_o, r_resp_o, r_last_o and r_id_o stay stable while r_valid_o=1 and r_ready_i=0.
- Burst-level errors (the whole burst responds SLVERR): burst != INCR(2'b01), size != 3'b010, or len > 15.
  - For a failed write burst, no writes occur and all W beats are still accepted.
  - For a failed read burst, all beats return data 0 with SLVERR.
- Beat-level errors:
  - Word index = (addr - BASE_ADDR)>>2. A beat whose index is >= MEM_WORDS, or whose addr < BASE_ADDR, is out of range.
  - An out-of-range write beat is dropped and sets the burst error flag.
  - An out-of-range read beat returns 0 with r_resp_o=SLVERR; in-range beats of the same burst return OKAY.
- Address arithmetic:
  - 64-bit, no wrap handling beyond natural overflow.
  - addr[1:0] is ignored: the address is aligned down, with no error.
- WLAST:
  - A mismatch (w_last_i=1 before the final beat, or 0 on the final beat) sets the error flag.
  - The burst length is always governed by len, never by w_last_i.
- Concurrency:
  - Read and write FSMs run fully concurrently.
  - Same-word read and write in the same cycle: the read returns the old value, and the new value is visible from the next cycle.
- aw_ready_o is 0 outside W_IDLE, and ar_ready_o is 0 outside R_IDLE.

Test Plan:
- Write 16-beat INCR at BASE+0x40 with data 0x1000+i, strb=F; then a 16-beat read of the same range -> B OKAY one cycle after the last W beat; R returns 0x1000..0x100F, r_last_o on beat 15 only, all OKAY.
- Partial strobe: preload 0xAABBCCDD, then a single-beat write 0x11223344 with strb=4'b0101 -> readback 0xAA22CC44.
- Out-of-range read: 4-beat read starting at word MEM_WORDS-2 -> beats 0-1 OKAY with data, beats 2-3 SLVERR with data 0; r_last_o on beat 3.
- Illegal burst: aw_burst=FIXED with len=3 -> all 4 W beats accepted, memory unchanged, b_resp_o=2'b10.
- Backpressure and concurrency:
  - r_ready_i toggles every other cycle during an 8-beat read -> r_data_o is held stable and no beats are lost.
  - A concurrent 8-beat write to a disjoint range completes and returns B OKAY.
  - b_ready_i held 0 for 5 cycles -> b_valid_o is held and aw_ready_o stays 0.
- Reset mid-read at beat 3 -> r_valid_o drops asynchronously; after release, ar_ready_o=1 and the next burst is served correctly.
